// File: rtl/jam_cost_server.sv
// Cost-table server for the JAM assignment engine: loads a 64-entry cost table,
// holds the engine in reset, serves (W,J) lookups, and captures the result or a timeout.
module jam_cost_server #(
    parameter int unsigned TIMEOUT_CYCLES = 10000000,
    parameter int unsigned RST_HOLD       = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ld_valid,
    input  logic [6:0] ld_data,
    output logic       ld_ready,
    output logic       jam_rst,
    input  logic [2:0] W,
    input  logic [2:0] J,
    output logic [6:0] Cost,
    input  logic       Valid,
    input  logic [8:0] MinCost,
    input  logic [3:0] MatchCount,
    output logic       res_valid,
    output logic [8:0] res_min_cost,
    output logic [3:0] res_match_count,
    output logic       timeout
);

    typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

    localparam logic [23:0] CNT_LAST  = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST = (RST_HOLD == 0) ? 32'd0 : 32'(RST_HOLD - 1);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] hold_q, hold_d;
    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  w_s_q, w_s_d, j_s_q, j_s_d;
    logic        res_valid_q, res_valid_d;
    logic [8:0]  res_min_cost_q, res_min_cost_d;
    logic [3:0]  res_match_count_q, res_match_count_d;
    logic        timeout_q, timeout_d;
    logic        tbl_we;
    logic [6:0]  table_q [64];

    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        hold_d            = hold_q;
        cnt_d             = cnt_q;
        res_valid_d       = res_valid_q;
        res_min_cost_d    = res_min_cost_q;
        res_match_count_d = res_match_count_q;
        timeout_d         = timeout_q;
        tbl_we            = 1'b0;
        w_s_d             = W;
        j_s_d             = J;
        case (state_q)
            S_LOAD: begin
                if (ld_valid) begin
                    tbl_we = 1'b1;
                    idx_d  = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 24'd1;
                // A real result wins over a timeout landing on the same cycle.
                if (Valid) begin
                    state_d           = S_DONE;
                    res_valid_d       = 1'b1;
                    res_min_cost_d    = MinCost;
                    res_match_count_d = MatchCount;
                    timeout_d         = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d           = S_DONE;
                    res_valid_d       = 1'b1;
                    res_min_cost_d    = '0;
                    res_match_count_d = '0;
                    timeout_d         = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q           <= S_LOAD;
            idx_q             <= '0;
            hold_q            <= '0;
            cnt_q             <= '0;
            w_s_q             <= '0;
            j_s_q             <= '0;
            res_valid_q       <= 1'b0;
            res_min_cost_q    <= '0;
            res_match_count_q <= '0;
            timeout_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            hold_q            <= hold_d;
            cnt_q             <= cnt_d;
            w_s_q             <= w_s_d;
            j_s_q             <= j_s_d;
            res_valid_q       <= res_valid_d;
            res_min_cost_q    <= res_min_cost_d;
            res_match_count_q <= res_match_count_d;
            timeout_q         <= timeout_d;
        end
    end

    // Table is deliberately not reset; every reset forces a complete reload.
    always_ff @(posedge CLK) begin
        if (tbl_we) table_q[idx_q] <= ld_data;
    end

    assign ld_ready        = (state_q == S_LOAD);
    assign jam_rst         = (state_q == S_LOAD) || (state_q == S_HOLD);
    assign Cost            = (state_q == S_RUN) ? table_q[{w_s_q, j_s_q}] : '0;
    assign res_valid       = res_valid_q;
    assign res_min_cost    = res_min_cost_q;
    assign res_match_count = res_match_count_q;
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_jam_cost_server.sv
// Directed self-checking bench for jam_cost_server (TIMEOUT_CYCLES=100, RST_HOLD=2).
module tb_jam_cost_server;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ld_valid = 1'b0;
    logic [6:0] ld_data = '0;
    logic       ld_ready, jam_rst;
    logic [2:0] W = '0, J = '0;
    logic [6:0] Cost;
    logic       Valid = 1'b0;
    logic [8:0] MinCost = '0;
    logic [3:0] MatchCount = '0;
    logic       res_valid, timeout;
    logic [8:0] res_min_cost;
    logic [3:0] res_match_count;

    int total = 0;
    int bad   = 0;

    jam_cost_server #(.TIMEOUT_CYCLES(100), .RST_HOLD(2)) dut (
        .CLK(CLK), .RST(RST), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .jam_rst(jam_rst), .W(W), .J(J), .Cost(Cost),
        .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .res_valid(res_valid), .res_min_cost(res_min_cost),
        .res_match_count(res_match_count), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Asserts RST between edges and checks outputs while it is still high.
    task automatic do_reset();
        RST = 1'b1;
        #1;
        total++;
        if (ld_ready !== 1'b1 || jam_rst !== 1'b1 || Cost !== 7'd0) begin
            bad++;
            $display("FAIL rst_ctl: ld_ready=%b jam_rst=%b Cost=%0d, want 1 1 0", ld_ready, jam_rst, Cost);
        end
        total++;
        if (res_valid !== 1'b0 || res_min_cost !== 9'd0 || res_match_count !== 4'd0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL rst_res: v=%b min=%0d cnt=%0d to=%b, want 0 0 0 0",
                     res_valid, res_min_cost, res_match_count, timeout);
        end
        step();
        step();
        RST = 1'b0;
    endtask

    // Loads 64 entries (value = inv ? 63-i : i) and checks the HOLD window timing.
    task automatic load_table(input bit gap, input bit inv);
        int unsigned edges = 0;
        W = 3'd3;
        J = 3'd5;
        for (int i = 0; i < 64; i++) begin
            if (gap) begin
                ld_valid = 1'b0;
                ld_data  = 7'h7f;
                step();
                edges++;
            end
            ld_valid = 1'b1;
            ld_data  = inv ? 7'(63 - i) : 7'(i);
            total++;
            if (ld_ready !== 1'b1 || jam_rst !== 1'b1) begin
                bad++;
                $display("FAIL load_beat%0d: ld_ready=%b jam_rst=%b, want 1 1", i, ld_ready, jam_rst);
            end
            step();
            edges++;
        end
        // Beats offered during HOLD must not touch the table.
        ld_valid = 1'b1;
        ld_data  = 7'h7f;
        total++;
        if (ld_ready !== 1'b0 || jam_rst !== 1'b1 || edges != (gap ? 128 : 64)) begin
            bad++;
            $display("FAIL load_end: ld_ready=%b jam_rst=%b edges=%0d, want 0 1 %0d",
                     ld_ready, jam_rst, edges, gap ? 128 : 64);
        end
        step();
        total++;
        if (jam_rst !== 1'b1 || Cost !== 7'd0) begin
            bad++;
            $display("FAIL hold1: jam_rst=%b Cost=%0d, want 1 0", jam_rst, Cost);
        end
        step();
        ld_valid = 1'b0;
        total++;
        if (jam_rst !== 1'b0 || ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL run_entry: jam_rst=%b ld_ready=%b, want 0 0", jam_rst, ld_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        load_table(1'b0, 1'b0);
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                W = 3'(w);
                J = 3'(j);
                exp = 7'(8 * w + j);
                step();
                total++;
                if (Cost !== exp) begin
                    bad++;
                    $display("FAIL lookup_w%0d_j%0d: Cost=%0d, want %0d", w, j, Cost, exp);
                end
            end
        end
        MinCost    = 9'd120;
        MatchCount = 4'd3;
        Valid      = 1'b1;
        step();
        Valid = 1'b0;
        total++;
        if (res_valid !== 1'b1 || res_min_cost !== 9'd120 || res_match_count !== 4'd3 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL capture: v=%b min=%0d cnt=%0d to=%b, want 1 120 3 0",
                     res_valid, res_min_cost, res_match_count, timeout);
        end
        total++;
        if (Cost !== 7'd0 || jam_rst !== 1'b0) begin
            bad++;
            $display("FAIL done_ctl: Cost=%0d jam_rst=%b, want 0 0", Cost, jam_rst);
        end
        MinCost    = 9'd5;
        MatchCount = 4'd9;
        Valid      = 1'b1;
        ld_valid   = 1'b1;
        step();
        step();
        Valid    = 1'b0;
        ld_valid = 1'b0;
        total++;
        if (res_valid !== 1'b1 || res_min_cost !== 9'd120 || res_match_count !== 4'd3 ||
            timeout !== 1'b0 || ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_hold: v=%b min=%0d cnt=%0d to=%b rdy=%b, want 1 120 3 0 0",
                     res_valid, res_min_cost, res_match_count, timeout, ld_ready);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        load_table(1'b0, 1'b0);
        MinCost    = 9'd77;
        MatchCount = 4'd6;
        Valid      = 1'b0;
        for (int c = 0; c < 99; c++) step();
        total++;
        if (res_valid !== 1'b0 || Cost !== 7'd29) begin
            bad++;
            $display("FAIL timeout_early: v=%b Cost=%0d, want 0 29", res_valid, Cost);
        end
        step();
        total++;
        if (res_valid !== 1'b1 || timeout !== 1'b1 || res_min_cost !== 9'd0 || res_match_count !== 4'd0) begin
            bad++;
            $display("FAIL timeout_fire: v=%b to=%b min=%0d cnt=%0d, want 1 1 0 0",
                     res_valid, timeout, res_min_cost, res_match_count);
        end
        total++;
        if (Cost !== 7'd0) begin
            bad++;
            $display("FAIL timeout_cost: Cost=%0d, want 0", Cost);
        end
    endtask

    task automatic test_valid_at_limit();
        do_reset();
        load_table(1'b0, 1'b0);
        MinCost    = 9'd300;
        MatchCount = 4'd11;
        Valid      = 1'b0;
        for (int c = 0; c < 99; c++) step();
        Valid = 1'b1;
        step();
        Valid = 1'b0;
        total++;
        if (res_valid !== 1'b1 || timeout !== 1'b0 || res_min_cost !== 9'd300 || res_match_count !== 4'd11) begin
            bad++;
            $display("FAIL valid_at_limit: v=%b to=%b min=%0d cnt=%0d, want 1 0 300 11",
                     res_valid, timeout, res_min_cost, res_match_count);
        end
    endtask

    task automatic test_mid_load_reset();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            ld_valid = 1'b1;
            ld_data  = 7'(i);
            step();
        end
        ld_valid = 1'b0;
        do_reset();
        load_table(1'b0, 1'b1);
        W = 3'd0;
        J = 3'd0;
        step();
        total++;
        if (Cost !== 7'd63) begin
            bad++;
            $display("FAIL reload_00: Cost=%0d, want 63", Cost);
        end
        W = 3'd7;
        J = 3'd7;
        step();
        total++;
        if (Cost !== 7'd0) begin
            bad++;
            $display("FAIL reload_77: Cost=%0d, want 0", Cost);
        end
        W = 3'd1;
        J = 3'd2;
        step();
        total++;
        if (Cost !== 7'd53) begin
            bad++;
            $display("FAIL reload_12: Cost=%0d, want 53", Cost);
        end
        // Reset during RUN: Cost must drop at once, before any clock edge.
        do_reset();
    endtask

    task automatic test_gapped_load();
        load_table(1'b1, 1'b0);
        W = 3'd7;
        J = 3'd7;
        step();
        total++;
        if (Cost !== 7'd63) begin
            bad++;
            $display("FAIL gap_77: Cost=%0d, want 63", Cost);
        end
        W = 3'd0;
        J = 3'd0;
        step();
        total++;
        if (Cost !== 7'd0) begin
            bad++;
            $display("FAIL gap_00: Cost=%0d, want 0", Cost);
        end
        W = 3'd3;
        J = 3'd5;
        step();
        total++;
        if (Cost !== 7'd29) begin
            bad++;
            $display("FAIL gap_35: Cost=%0d, want 29", Cost);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_back_to_back();
        test_timeout();
        test_valid_at_limit();
        test_mid_load_reset();
        test_gapped_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
